// File: rtl/valu_pkg.sv
// Shared op codes and FSM state encoding for the lane-serial vector ALU.
package valu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_NAND = 3'b011;
  localparam logic [2:0] OP_SHL  = 3'b100;
  localparam logic [2:0] OP_SHR  = 3'b101;
  localparam logic [2:0] OP_SRA  = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/valu_lane.sv
// Combinational single-lane ALU: seven ops, signed overflow flag, optional
// saturation on add/sub.
module valu_lane
  import valu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             sat,
  output logic [WIDTH-1:0] y,
  output logic             v
);

  localparam int unsigned SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [SW-1:0]    s;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] clamp;
  logic             add_ov;
  logic             sub_ov;

  assign s      = b[SW-1:0];
  assign sum    = a + b;
  assign diff   = a - b;
  assign add_ov = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  assign sub_ov = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
  // Overflow direction follows the sign of a for both add and sub.
  assign clamp  = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};

  always_comb begin
    y = '0;
    v = 1'b0;
    case (op)
      OP_ADD: begin
        v = add_ov;
        y = (sat && add_ov) ? clamp : sum;
      end
      OP_SUB: begin
        v = sub_ov;
        y = (sat && sub_ov) ? clamp : diff;
      end
      OP_OR:   y = a | b;
      OP_NAND: y = ~(a & b);
      OP_SHL:  y = a << s;
      OP_SHR:  y = a >> s;
      OP_SRA:  y = WIDTH'($signed(a) >>> s);
      default: begin
        y = '0;
        v = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/valu_seq.sv
// Lane-serial vector ALU: one shared lane ALU walks LANES lanes under a
// start/done handshake; results publish atomically on RUN->DONE.
module valu_seq
  import valu_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LANES = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [2:0]             op,
  input  logic                   sat,
  input  logic [LANES*WIDTH-1:0] in1,
  input  logic [LANES*WIDTH-1:0] in2,
  output logic                   busy,
  output logic                   done,
  output logic [LANES*WIDTH-1:0] out,
  output logic [LANES-1:0]       lane_n,
  output logic [LANES-1:0]       lane_z,
  output logic [LANES-1:0]       lane_v
);

  localparam int unsigned IW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(LANES - 1);

  state_t state, state_nxt;

  logic [LANES*WIDTH-1:0] a_r;
  logic [LANES*WIDTH-1:0] b_r;
  logic [2:0]             op_r;
  logic                   sat_r;
  logic [IW-1:0]          idx;
  logic [LANES*WIDTH-1:0] shadow;
  logic [LANES-1:0]       shadow_v;

  logic [WIDTH-1:0]       lane_a;
  logic [WIDTH-1:0]       lane_b;
  logic [WIDTH-1:0]       lane_y;
  logic                   lane_ov;
  logic [LANES*WIDTH-1:0] shadow_nxt;
  logic [LANES-1:0]       shadow_v_nxt;
  logic [LANES-1:0]       res_n;
  logic [LANES-1:0]       res_z;
  logic                   accept;

  valu_lane #(.WIDTH(WIDTH)) u_lane (
    .a   (lane_a),
    .b   (lane_b),
    .op  (op_r),
    .sat (sat_r),
    .y   (lane_y),
    .v   (lane_ov)
  );

  always_comb begin
    lane_a = a_r[idx*WIDTH +: WIDTH];
    lane_b = b_r[idx*WIDTH +: WIDTH];
  end

  // The final lane bypasses the shadow so the published vector includes it.
  always_comb begin
    shadow_nxt                      = shadow;
    shadow_nxt[idx*WIDTH +: WIDTH]  = lane_y;
    shadow_v_nxt                    = shadow_v;
    shadow_v_nxt[idx]               = lane_ov;
    res_n                           = '0;
    res_z                           = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      res_n[i] = shadow_nxt[i*WIDTH + WIDTH - 1];
      res_z[i] = (shadow_nxt[i*WIDTH +: WIDTH] == '0);
    end
  end

  assign accept = start && (state != S_RUN);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (idx == LAST_IDX) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = start ? S_RUN : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      a_r      <= '0;
      b_r      <= '0;
      op_r     <= '0;
      sat_r    <= 1'b0;
      idx      <= '0;
      shadow   <= '0;
      shadow_v <= '0;
      out      <= '0;
      lane_n   <= '0;
      lane_z   <= '0;
      lane_v   <= '0;
    end else if (accept) begin
      a_r   <= in1;
      b_r   <= in2;
      op_r  <= op;
      sat_r <= sat;
      idx   <= '0;
    end else if (state == S_RUN) begin
      shadow   <= shadow_nxt;
      shadow_v <= shadow_v_nxt;
      if (idx == LAST_IDX) begin
        idx    <= '0;
        out    <= shadow_nxt;
        lane_n <= res_n;
        lane_z <= res_z;
        lane_v <= shadow_v_nxt;
      end else begin
        idx <= idx + IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_valu_seq.sv
// Directed table-driven bench for valu_seq (WIDTH=8, LANES=4) plus
// hand-written reset, back-to-back and input-hold sequences.
module tb_valu_seq;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op    = 3'b000;
  logic        sat   = 1'b0;
  logic [31:0] in1   = '0;
  logic [31:0] in2   = '0;
  logic        busy;
  logic        done;
  logic [31:0] out;
  logic [3:0]  lane_n;
  logic [3:0]  lane_z;
  logic [3:0]  lane_v;

  int n_vec = 0;
  int n_bad = 0;

  valu_seq #(.WIDTH(8), .LANES(4)) dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .sat    (sat),
    .in1    (in1),
    .in2    (in2),
    .busy   (busy),
    .done   (done),
    .out    (out),
    .lane_n (lane_n),
    .lane_z (lane_z),
    .lane_v (lane_v)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  typedef struct {
    logic [2:0]  op;
    logic        sat;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [31:0] out;
    logic [3:0]  n;
    logic [3:0]  z;
    logic [3:0]  v;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  task automatic run_vec(input vec_t t, output int lat, output logic busy1);
    @(negedge clock);
    op    = t.op;
    sat   = t.sat;
    in1   = t.in1;
    in2   = t.in2;
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    lat   = 0;
    busy1 = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      if (k == 1) busy1 = busy;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic check_result(input string nm, input vec_t t);
    chk({nm, " out"},    out,           t.out);
    chk({nm, " lane_n"}, {28'd0, lane_n}, {28'd0, t.n});
    chk({nm, " lane_z"}, {28'd0, lane_z}, {28'd0, t.z});
    chk({nm, " lane_v"}, {28'd0, lane_v}, {28'd0, t.v});
  endtask

  initial begin
    int   lat;
    logic b1;
    vec_t add_v;

    //        op      sat   in1           in2           out           n        z        v
    tbl[0] = '{3'b000, 1'b0, 32'h7F01FF10, 32'h01010110, 32'h80020020, 4'b1000, 4'b0010, 4'b1000};
    tbl[1] = '{3'b001, 1'b1, 32'h8005007F, 32'h010501FF, 32'h8000FF7F, 4'b1010, 4'b0100, 4'b1001};
    tbl[2] = '{3'b110, 1'b0, 32'h80808080, 32'h00010709, 32'h80C0FFC0, 4'b1111, 4'b0000, 4'b0000};
    tbl[3] = '{3'b100, 1'b1, 32'h01010101, 32'h00010708, 32'h01028001, 4'b0010, 4'b0000, 4'b0000};
    tbl[4] = '{3'b010, 1'b0, 32'hF00F00AA, 32'h0F000055, 32'hFF0F00FF, 4'b1001, 4'b0010, 4'b0000};
    tbl[5] = '{3'b011, 1'b0, 32'hFFFF00F0, 32'hFF00003C, 32'h00FFFFCF, 4'b0111, 4'b1000, 4'b0000};
    tbl[6] = '{3'b111, 1'b1, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 4'b0000, 4'b1111, 4'b0000};
    tbl[7] = '{3'b000, 1'b1, 32'h7F8040C0, 32'h01FF40C0, 32'h7F807F80, 4'b0101, 4'b0000, 4'b1110};
    tbl[8] = '{3'b001, 1'b0, 32'h8000107F, 32'h018010FF, 32'h7F800080, 4'b0101, 4'b0010, 4'b1101};
    tbl[9] = '{3'b101, 1'b0, 32'h80FF80F0, 32'h0704000C, 32'h010F800F, 4'b0010, 4'b0000, 4'b0000};
    add_v  = tbl[0];

    // Reset state
    #22;
    chk("reset busy",   {31'd0, busy},   32'd0);
    chk("reset done",   {31'd0, done},   32'd0);
    chk("reset out",    out,             32'd0);
    chk("reset lane_z", {28'd0, lane_z}, 32'd0);
    chk("reset lane_n", {28'd0, lane_n}, 32'd0);
    chk("reset lane_v", {28'd0, lane_v}, 32'd0);
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_vec(tbl[i], lat, b1);
      chk($sformatf("vec%0d latency", i), lat, 32'd5);
      chk($sformatf("vec%0d busy", i), {31'd0, b1}, 32'd1);
      check_result($sformatf("vec%0d", i), tbl[i]);
    end

    // Asynchronous reset two cycles into a run
    @(negedge clock);
    op = add_v.op; sat = add_v.sat; in1 = add_v.in1; in2 = add_v.in2;
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("midrun busy before reset", {31'd0, busy}, 32'd1);
    chk("midrun out held", out, tbl[9].out);
    #2 reset = 1'b0;
    #1;
    chk("midrun reset busy",   {31'd0, busy},   32'd0);
    chk("midrun reset done",   {31'd0, done},   32'd0);
    chk("midrun reset out",    out,             32'd0);
    chk("midrun reset lane_n", {28'd0, lane_n}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    run_vec(add_v, lat, b1);
    chk("post-reset latency", lat, 32'd5);
    check_result("post-reset add", add_v);

    // Back-to-back with start held high; in1 disturbed mid-run
    @(negedge clock);
    op = add_v.op; sat = add_v.sat; in1 = add_v.in1; in2 = add_v.in2;
    start = 1'b1;
    @(posedge clock);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clock);
      chk($sformatf("b2b done k=%0d", k), {31'd0, done}, {31'd0, (k % 5) == 0});
      if (k == 7) begin
        chk("b2b out held in run", out, add_v.out);
        in1 = 32'hDEADBEEF;
      end
      if (k == 8) in1 = add_v.in1;
      if ((k % 5) == 0) chk($sformatf("b2b out k=%0d", k), out, add_v.out);
    end
    start = 1'b0;
    @(negedge clock);
    chk("b2b idle busy", {31'd0, busy}, 32'd0);
    chk("b2b idle done", {31'd0, done}, 32'd0);
    chk("b2b idle out",  out,           add_v.out);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
